unsigned_sqrt_radix2: RTL and testbench

//  Iterative radix-2 restoring integer square-root core: the responder end of

---
 rtl/unsigned_sqrt_radix2_if.sv | 22 ++
 rtl/unsigned_sqrt_radix2.sv | 73 +++++++
 tb/tb_unsigned_sqrt_radix2.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/unsigned_sqrt_radix2_if.sv
// Request/response bundle between the FP square-root unit (master) and the
// iterative integer square-root core (slave).
interface unsigned_sqrt_radix2_if #(
   parameter int unsigned DATA_WIDTH = 57
);
   logic                  start;
   logic [DATA_WIDTH-1:0] radicand;
   logic                  busy;
   logic                  done;
   logic [DATA_WIDTH-1:0] result;
   logic [DATA_WIDTH:0]   remainder;

   modport master (
      output start, radicand,
      input  busy, done, result, remainder
   );

   modport slave (
      input  start, radicand,
      output busy, done, result, remainder
   );
endinterface

// File: rtl/unsigned_sqrt_radix2.sv
// Radix-2 restoring integer square root: one root bit per cycle,
// Q = floor(sqrt(R * 2^W)) plus the exact remainder R * 2^W - Q^2.
module unsigned_sqrt_radix2 #(
   parameter int unsigned DATA_WIDTH = 57
) (
   input logic                   clk,
   input logic                   rst,
   unsigned_sqrt_radix2_if.slave sif
);
   localparam int unsigned W  = DATA_WIDTH;
   localparam int unsigned CW = $clog2(W);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]     state;
   logic [W-1:0]   rem;
   logic [W-1:0]   q;
   logic [2*W-1:0] x;
   logic [CW-1:0]  cnt;

   logic [W+1:0]   p;
   logic [W+1:0]   t;
   logic           ge;
   logic [W:0]     rem_nxt;
   logic [W-1:0]   q_nxt;

   // Partial remainder never exceeds 2q, so W stored bits suffice between
   // steps; the subtraction only needs W+1 bits because the result fits there.
   always_comb begin
      p       = {rem, x[2*W-1 -: 2]};
      t       = {q, 2'b01};
      ge      = (p >= t);
      rem_nxt = ge ? (p[W:0] - t[W:0]) : p[W:0];
      q_nxt   = {q[W-2:0], ge};
   end

   assign sif.busy = (state == RUN);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         rem           <= '0;
         q             <= '0;
         x             <= '0;
         cnt           <= '0;
         sif.done      <= 1'b0;
         sif.result    <= '0;
         sif.remainder <= '0;
      end else begin
         sif.done <= 1'b0;
         if (sif.start) begin
            // A new request always wins, abandoning any op in flight.
            state <= RUN;
            x     <= {sif.radicand, {W{1'b0}}};
            rem   <= '0;
            q     <= '0;
            cnt   <= CW'(W - 1);
         end else if (state == RUN) begin
            rem <= rem_nxt[W-1:0];
            q   <= q_nxt;
            x   <= x << 2;
            cnt <= cnt - CW'(1);
            if (cnt == '0) begin
               state         <= IDLE;
               sif.done      <= 1'b1;
               sif.result    <= q_nxt;
               sif.remainder <= rem_nxt;
            end
         end
      end
   end
endmodule

// File: tb/tb_unsigned_sqrt_radix2.sv
// Bench for unsigned_sqrt_radix2: W=8 directed/exhaustive via a scoreboard,
// W=57 random checked against the defining identity Q^2 + rem == R << W.
module tb_unsigned_sqrt_radix2;
   typedef struct {
      logic [7:0] r;
      logic [7:0] q;
      logic [8:0] rm;
   } vec_t;

   typedef struct {
      logic [7:0]  r;
      logic [7:0]  q;
      logic [8:0]  rm;
      int unsigned due;
   } sb_t;

   logic        clk;
   logic        rst;
   int unsigned cyc;
   int          total;
   int          bad;
   sb_t         sb[$];
   sb_t         e;
   logic        prev_done;
   vec_t        vecs[8];

   unsigned_sqrt_radix2_if #(.DATA_WIDTH(8))  if8 ();
   unsigned_sqrt_radix2_if #(.DATA_WIDTH(57)) if57 ();

   unsigned_sqrt_radix2 #(.DATA_WIDTH(8)) dut8 (
      .clk (clk),
      .rst (rst),
      .sif (if8.slave)
   );

   unsigned_sqrt_radix2 #(.DATA_WIDTH(57)) dut57 (
      .clk (clk),
      .rst (rst),
      .sif (if57.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model8(input int r, output logic [7:0] q, output logic [8:0] rm);
      int x;
      int k;
      x = r * 256;
      k = 255;
      while (k * k > x) k--;
      q  = 8'(k);
      rm = 9'(x - k * k);
   endtask

   // Called in the cycle the request is presented; returns one cycle later.
   task automatic issue8(input logic [7:0] r, input logic [7:0] q, input logic [8:0] rm);
      sb_t s;
      if8.start    = 1'b1;
      if8.radicand = r;
      s.r = r; s.q = q; s.rm = rm; s.due = cyc + 9;
      sb.push_back(s);
      tick();
      if8.start    = 1'b0;
      if8.radicand = 8'($urandom);
   endtask

   task automatic drain(input int max);
      for (int n = 0; n < max && sb.size() != 0; n++) begin
         @(negedge clk);
         #1;
      end
      chk("drain_pending", 128'(sb.size()), 128'd0);
      sb.delete();
   endtask

   initial prev_done = 1'b0;
   always @(negedge clk) begin
      if (rst && if8.done) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL done8_unexpected actual=1 required=0 result=%0h", if8.result);
         end else begin
            e = sb.pop_front();
            chk("result8", 128'(if8.result), 128'(e.q));
            chk("remainder8", 128'(if8.remainder), 128'(e.rm));
            chk("latency8", 128'(cyc), 128'(e.due));
            chk("done_pulse8", 128'(prev_done), 128'd0);
         end
      end
      prev_done = if8.done;
   end

   initial begin
      logic [7:0]   mq;
      logic [8:0]   mrm;
      logic [56:0]  rv;
      logic [127:0] qq;
      logic [127:0] lhs;
      logic [127:0] rhs;
      int           n;
      int           dcount;

      total = 0;
      bad   = 0;
      vecs[0] = '{8'h40, 8'h80, 9'h000};
      vecs[1] = '{8'h80, 8'hB5, 9'h007};
      vecs[2] = '{8'hFF, 8'hFF, 9'h0FF};
      vecs[3] = '{8'h01, 8'h10, 9'h000};
      vecs[4] = '{8'h00, 8'h00, 9'h000};
      vecs[5] = '{8'h02, 8'h16, 9'h01C};
      vecs[6] = '{8'hC8, 8'hE2, 9'h07C};
      vecs[7] = '{8'h55, 8'h93, 9'h097};

      rst           = 1'b0;
      if8.start     = 1'b0;
      if8.radicand  = '0;
      if57.start    = 1'b0;
      if57.radicand = '0;

      @(negedge clk);
      @(negedge clk);
      chk("reset_busy", 128'(if8.busy), 128'd0);
      chk("reset_done", 128'(if8.done), 128'd0);
      chk("reset_result", 128'(if8.result), 128'd0);
      chk("reset_remainder", 128'(if8.remainder), 128'd0);
      tick();
      rst = 1'b1;

      foreach (vecs[i]) begin
         tick();
         issue8(vecs[i].r, vecs[i].q, vecs[i].rm);
         chk("busy_running", 128'(if8.busy), 128'd1);
         drain(14);
         chk("busy_idle", 128'(if8.busy), 128'd0);
      end

      // Preemption: 0xFF abandoned, restart four cycles later with 0x40.
      tick();
      if8.start    = 1'b1;
      if8.radicand = 8'hFF;
      tick();
      if8.start    = 1'b0;
      tick();
      tick();
      tick();
      issue8(8'h40, 8'h80, 9'h000);
      drain(16);

      // Start held for three cycles: only the last radicand completes.
      tick();
      if8.start    = 1'b1;
      if8.radicand = 8'hFF;
      tick();
      if8.radicand = 8'h01;
      tick();
      issue8(8'h80, 8'hB5, 9'h007);
      drain(16);

      // New request in the done cycle; old result must hold until completion.
      tick();
      issue8(8'h80, 8'hB5, 9'h007);
      repeat (8) tick();
      issue8(8'h40, 8'h80, 9'h000);
      chk("hold_result", 128'(if8.result), 128'hB5);
      chk("hold_remainder", 128'(if8.remainder), 128'h007);
      chk("hold_busy", 128'(if8.busy), 128'd1);
      drain(16);

      // Reset mid-operation: outputs clear at once, no late done.
      tick();
      if8.start    = 1'b1;
      if8.radicand = 8'hFF;
      tick();
      if8.start    = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("midrst_busy", 128'(if8.busy), 128'd0);
      chk("midrst_done", 128'(if8.done), 128'd0);
      chk("midrst_result", 128'(if8.result), 128'd0);
      chk("midrst_remainder", 128'(if8.remainder), 128'd0);
      tick();
      tick();
      rst    = 1'b0;
      tick();
      rst    = 1'b1;
      dcount = 0;
      repeat (14) begin
         @(negedge clk);
         if (if8.done) dcount++;
      end
      chk("midrst_no_done", 128'(dcount), 128'd0);
      chk("midrst_busy_after", 128'(if8.busy), 128'd0);

      for (int r = 0; r < 256; r++) begin
         model8(r, mq, mrm);
         tick();
         issue8(8'(r), mq, mrm);
         drain(14);
      end

      for (int i = 0; i < 150; i++) begin
         case (i)
            0:       rv = '0;
            1:       rv = 57'd1;
            2:       rv = '1;
            3:       rv = 57'd1 << 56;
            default: begin
               rv = 57'({$urandom, $urandom});
               if (i % 4 == 0) rv[56] = 1'b1;
            end
         endcase
         tick();
         if57.start    = 1'b1;
         if57.radicand = rv;
         tick();
         if57.start    = 1'b0;
         if57.radicand = 57'({$urandom, $urandom});
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!if57.done && n < 80);
         chk("latency57", 128'(n), 128'd58);
         qq  = 128'(if57.result);
         lhs = qq * qq + 128'(if57.remainder);
         rhs = 128'(rv) << 57;
         chk("identity57", lhs, rhs);
         chk("rem_le_2q57", 128'(128'(if57.remainder) <= 2 * qq), 128'd1);
         if (rv[56:55] != 2'b00) chk("hidden_bit57", 128'(if57.result[56]), 128'd1);
         @(negedge clk);
         chk("done_pulse57", 128'(if57.done), 128'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
